// File: rtl/ctrl_pipe_hazard.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_hazard
//
// Pipeline control unit. It decodes the ID-stage opcode into a control bundle
// and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It
// also detects load-use hazards, squashes the ID instruction when a branch in
// EX resolves taken, and produces the EX operand forwarding selects. The
// datapath holds only data registers; all control state lives in this block.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   id_valid            IF/ID register holds a real instruction
//   id_op               6-bit opcode in ID
//   id_rs/id_rt/id_rd   register specifiers in ID
//   ex_branch_taken     branch in EX resolved taken
//   stall               hold PC and IF/ID (combinational)
//   flush               clear IF/ID (combinational)
//   id_illegal          valid ID instruction with an unsupported opcode
//   ex_*                ID/EX control bundle and specifiers
//   fwd_a, fwd_b        00 regfile, 10 EX/MEM result, 01 MEM/WB result
//   mem_*               EX/MEM control bundle
//   wb_*                MEM/WB control bundle
// -----------------------------------------------------------------------------
module ctrl_pipe_hazard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 3,
    parameter bit          EXT_ISA    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [5:0]            id_op,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic                  id_illegal,
    output logic                  ex_valid,
    output logic                  ex_regdst,
    output logic                  ex_alusrc,
    output logic                  ex_branch,
    output logic                  ex_bne,
    output logic                  ex_zext,
    output logic                  ex_rtype,
    output logic                  ex_memread,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_valid,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_regwrite,
    output logic                  mem_memtoreg,
    output logic                  mem_jal,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  wb_valid,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic                  wb_jal,
    output logic [REG_ADDR_W-1:0] wb_dest
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_SLTI  = 6'b001010,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    // ID/EX carries the full bundle; later stages keep only what they consume.
    typedef struct packed {
        logic                  valid;
        logic                  regdst;
        logic                  alusrc;
        logic                  branch;
        logic                  bne;
        logic                  zext;
        logic                  rtype;
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  jal;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
    } idex_t;

    typedef struct packed {
        logic                  valid;
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  jal;
        logic [REG_ADDR_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  jal;
        logic [REG_ADDR_W-1:0] dest;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    idex_t  dec;
    logic   dec_legal;
    logic   dec_rt_src;
    logic   load_use;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        dec        = '0;
        dec_legal  = 1'b1;
        dec_rt_src = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                dec.regdst   = 1'b1;
                dec.aluop    = ALUOP_W'(3'b010);
                dec.regwrite = 1'b1;
                dec.rtype    = 1'b1;
                dec_rt_src   = 1'b1;
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec_rt_src   = 1'b1;
            end
            OP_BEQ: begin
                dec.branch   = 1'b1;
                dec.aluop    = ALUOP_W'(3'b001);
                dec_rt_src   = 1'b1;
            end
            OP_BNE: begin
                dec.bne      = 1'b1;
                dec.aluop    = ALUOP_W'(3'b001);
                dec_rt_src   = 1'b1;
            end
            OP_ANDI: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = ALUOP_W'(3'b100);
                dec.regwrite = 1'b1;
                dec.zext     = 1'b1;
            end
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_ORI: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = ALUOP_W'(3'b011);
                dec.regwrite = 1'b1;
                dec.zext     = 1'b1;
            end
            OP_JAL: begin
                dec.jal      = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_SLTI: begin
                if (EXT_ISA) begin
                    dec.alusrc   = 1'b1;
                    dec.aluop    = ALUOP_W'(3'b101);
                    dec.regwrite = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_XORI: begin
                if (EXT_ISA) begin
                    dec.alusrc   = 1'b1;
                    dec.aluop    = ALUOP_W'(3'b110);
                    dec.regwrite = 1'b1;
                    dec.zext     = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_LUI: begin
                if (EXT_ISA) begin
                    dec.alusrc   = 1'b1;
                    dec.aluop    = ALUOP_W'(3'b111);
                    dec.regwrite = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_J: begin
                if (!EXT_ISA) begin
                    dec_legal = 1'b0;
                end
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase

        // Illegal opcodes flow on as harmless valid instructions.
        if (!dec_legal) begin
            dec.aluop = ALUOP_W'(3'b001);
        end

        dec.valid = 1'b1;
        dec.rs    = id_rs;
        dec.rt    = id_rt;

        if (!dec.regwrite) begin
            dec.dest = '0;
        end else if (dec.jal) begin
            dec.dest = '1;
        end else if (dec.regdst) begin
            dec.dest = id_rd;
        end else begin
            dec.dest = id_rt;
        end
    end

    assign id_illegal = id_valid & ~dec_legal;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign flush = ex_branch_taken;

    always_comb begin
        load_use = id_valid && idex_q.valid && idex_q.memread &&
                   (idex_q.dest != '0) &&
                   ((idex_q.dest == id_rs) ||
                    (dec_rt_src && (idex_q.dest == id_rt)));
        // A taken branch squashes the ID instruction anyway, so it wins.
        stall = load_use && !flush;
    end

    // ------------------------------------------------------------------
    // Forwarding selects
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input exmem_t                m,
        input memwb_t                w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m.valid && m.regwrite && (m.dest != '0) && (m.dest == src)) begin
            sel = 2'b10;
        end else if (w.valid && w.regwrite && (w.dest != '0) && (w.dest == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    assign fwd_b = fwd_sel(idex_q.rt, exmem_q, memwb_q);

    // ------------------------------------------------------------------
    // Pipeline register next-state
    // ------------------------------------------------------------------
    always_comb begin
        idex_d = '0;
        if (id_valid && !stall && !flush) begin
            idex_d = dec;
        end

        exmem_d.valid    = idex_q.valid;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.jal      = idex_q.jal;
        exmem_d.dest     = idex_q.dest;

        memwb_d.valid    = exmem_q.valid;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.jal      = exmem_q.jal;
        memwb_d.dest     = exmem_q.dest;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign ex_valid     = idex_q.valid;
    assign ex_regdst    = idex_q.regdst;
    assign ex_alusrc    = idex_q.alusrc;
    assign ex_branch    = idex_q.branch;
    assign ex_bne       = idex_q.bne;
    assign ex_zext      = idex_q.zext;
    assign ex_rtype     = idex_q.rtype;
    assign ex_memread   = idex_q.memread;
    assign ex_aluop     = idex_q.aluop;
    assign ex_rs        = idex_q.rs;
    assign ex_rt        = idex_q.rt;
    assign ex_dest      = idex_q.dest;

    assign mem_valid    = exmem_q.valid;
    assign mem_memread  = exmem_q.memread;
    assign mem_memwrite = exmem_q.memwrite;
    assign mem_regwrite = exmem_q.regwrite;
    assign mem_memtoreg = exmem_q.memtoreg;
    assign mem_jal      = exmem_q.jal;
    assign mem_dest     = exmem_q.dest;

    assign wb_valid     = memwb_q.valid;
    assign wb_regwrite  = memwb_q.regwrite;
    assign wb_memtoreg  = memwb_q.memtoreg;
    assign wb_jal       = memwb_q.jal;
    assign wb_dest      = memwb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe_hazard
//
// Drives two instances (EXT_ISA=0 and EXT_ISA=1) with identical stimulus and
// compares every output each cycle against an instruction-level pipeline
// model: a decode table plus a three-entry array of in-flight instructions.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe_hazard;

    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_op = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_branch_taken = 1'b0;

    logic [1:0] stall_o, flush_o, illegal_o;
    logic [1:0] ex_valid_o, ex_regdst_o, ex_alusrc_o, ex_branch_o, ex_bne_o;
    logic [1:0] ex_zext_o, ex_rtype_o, ex_memread_o;
    logic [2:0] ex_aluop_o [2];
    logic [4:0] ex_rs_o [2];
    logic [4:0] ex_rt_o [2];
    logic [4:0] ex_dest_o [2];
    logic [1:0] fwd_a_o [2];
    logic [1:0] fwd_b_o [2];
    logic [1:0] mem_valid_o, mem_memread_o, mem_memwrite_o, mem_regwrite_o;
    logic [1:0] mem_memtoreg_o, mem_jal_o;
    logic [4:0] mem_dest_o [2];
    logic [1:0] wb_valid_o, wb_regwrite_o, wb_memtoreg_o, wb_jal_o;
    logic [4:0] wb_dest_o [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ctrl_pipe_hazard #(
            .REG_ADDR_W (5),
            .ALUOP_W    (3),
            .EXT_ISA    (g == 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .id_valid        (id_valid),
            .id_op           (id_op),
            .id_rs           (id_rs),
            .id_rt           (id_rt),
            .id_rd           (id_rd),
            .ex_branch_taken (ex_branch_taken),
            .stall           (stall_o[g]),
            .flush           (flush_o[g]),
            .id_illegal      (illegal_o[g]),
            .ex_valid        (ex_valid_o[g]),
            .ex_regdst       (ex_regdst_o[g]),
            .ex_alusrc       (ex_alusrc_o[g]),
            .ex_branch       (ex_branch_o[g]),
            .ex_bne          (ex_bne_o[g]),
            .ex_zext         (ex_zext_o[g]),
            .ex_rtype        (ex_rtype_o[g]),
            .ex_memread      (ex_memread_o[g]),
            .ex_aluop        (ex_aluop_o[g]),
            .ex_rs           (ex_rs_o[g]),
            .ex_rt           (ex_rt_o[g]),
            .ex_dest         (ex_dest_o[g]),
            .fwd_a           (fwd_a_o[g]),
            .fwd_b           (fwd_b_o[g]),
            .mem_valid       (mem_valid_o[g]),
            .mem_memread     (mem_memread_o[g]),
            .mem_memwrite    (mem_memwrite_o[g]),
            .mem_regwrite    (mem_regwrite_o[g]),
            .mem_memtoreg    (mem_memtoreg_o[g]),
            .mem_jal         (mem_jal_o[g]),
            .mem_dest        (mem_dest_o[g]),
            .wb_valid        (wb_valid_o[g]),
            .wb_regwrite     (wb_regwrite_o[g]),
            .wb_memtoreg     (wb_memtoreg_o[g]),
            .wb_jal          (wb_jal_o[g]),
            .wb_dest         (wb_dest_o[g])
        );
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       v, regdst, alusrc, branch, bne, zext, rtype, memread;
        logic       memwrite, regwrite, memtoreg, jal;
        logic [2:0] aluop;
        logic [4:0] rs, rt, dest;
        logic       rt_src, legal;
    } ins_t;

    ins_t ex_m [2];
    ins_t mem_m [2];
    ins_t wb_m [2];

    function automatic ins_t decode(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input bit ext);
        ins_t d;
        d = '0;
        d.v = 1'b1; d.rs = rs; d.rt = rt; d.legal = 1'b1;
        case (op)
            6'b000000: begin d.regdst = 1; d.aluop = 3'd2; d.regwrite = 1; d.rtype = 1; d.rt_src = 1; end
            6'b100011: begin d.alusrc = 1; d.memtoreg = 1; d.regwrite = 1; d.memread = 1; end
            6'b101011: begin d.alusrc = 1; d.memwrite = 1; d.rt_src = 1; end
            6'b000100: begin d.branch = 1; d.aluop = 3'd1; d.rt_src = 1; end
            6'b000101: begin d.bne = 1; d.aluop = 3'd1; d.rt_src = 1; end
            6'b001100: begin d.alusrc = 1; d.aluop = 3'd4; d.regwrite = 1; d.zext = 1; end
            6'b001000: begin d.alusrc = 1; d.regwrite = 1; end
            6'b001101: begin d.alusrc = 1; d.aluop = 3'd3; d.regwrite = 1; d.zext = 1; end
            6'b000011: begin d.jal = 1; d.regwrite = 1; end
            6'b001010: if (ext) begin d.aluop = 3'd5; d.alusrc = 1; d.regwrite = 1; end else d.legal = 0;
            6'b001110: if (ext) begin d.aluop = 3'd6; d.alusrc = 1; d.regwrite = 1; d.zext = 1; end else d.legal = 0;
            6'b001111: if (ext) begin d.aluop = 3'd7; d.alusrc = 1; d.regwrite = 1; end else d.legal = 0;
            6'b000010: if (!ext) d.legal = 0;
            default:   d.legal = 0;
        endcase
        if (!d.legal) d.aluop = 3'd1;
        d.dest = !d.regwrite ? 5'd0 : d.jal ? 5'd31 : d.regdst ? rd : rt;
        return d;
    endfunction

    function automatic logic exp_stall(input int e);
        ins_t x, n;
        x = ex_m[e];
        n = decode(id_op, id_rs, id_rt, id_rd, e == 1);
        return id_valid && x.v && x.memread && (x.dest != 0) &&
               ((x.dest == id_rs) || (n.rt_src && x.dest == id_rt)) && !ex_branch_taken;
    endfunction

    function automatic logic [1:0] exp_fwd(input int e, input logic [4:0] src);
        if (mem_m[e].v && mem_m[e].regwrite && mem_m[e].dest != 0 && mem_m[e].dest == src) return 2'b10;
        if (wb_m[e].v && wb_m[e].regwrite && wb_m[e].dest != 0 && wb_m[e].dest == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_ex(input int e);
        ins_t x;
        x = ex_m[e];
        return {6'd0, x.v, x.regdst, x.alusrc, x.branch, x.bne, x.zext, x.rtype,
                x.memread, x.aluop, x.rs, x.rt, x.dest};
    endfunction

    function automatic logic [31:0] dut_ex(input int e);
        return {6'd0, ex_valid_o[e], ex_regdst_o[e], ex_alusrc_o[e], ex_branch_o[e],
                ex_bne_o[e], ex_zext_o[e], ex_rtype_o[e], ex_memread_o[e],
                ex_aluop_o[e], ex_rs_o[e], ex_rt_o[e], ex_dest_o[e]};
    endfunction

    function automatic logic [31:0] model_mem(input int e);
        ins_t x;
        x = mem_m[e];
        return {21'd0, x.v, x.memread, x.memwrite, x.regwrite, x.memtoreg, x.jal, x.dest};
    endfunction

    function automatic logic [31:0] dut_mem(input int e);
        return {21'd0, mem_valid_o[e], mem_memread_o[e], mem_memwrite_o[e],
                mem_regwrite_o[e], mem_memtoreg_o[e], mem_jal_o[e], mem_dest_o[e]};
    endfunction

    function automatic logic [31:0] model_wb(input int e);
        ins_t x;
        x = wb_m[e];
        return {23'd0, x.v, x.regwrite, x.memtoreg, x.jal, x.dest};
    endfunction

    function automatic logic [31:0] dut_wb(input int e);
        return {23'd0, wb_valid_o[e], wb_regwrite_o[e], wb_memtoreg_o[e],
                wb_jal_o[e], wb_dest_o[e]};
    endfunction

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic br);
        @(negedge clk);
        rst = r; id_valid = v; id_op = op;
        id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = br;
        #1;
    endtask

    task automatic model_check();
        for (int e = 0; e < 2; e++) begin
            ins_t n;
            n = decode(id_op, id_rs, id_rt, id_rd, e == 1);
            check($sformatf("stall[%0d]", e), 32'(stall_o[e]), 32'(exp_stall(e)));
            check($sformatf("flush[%0d]", e), 32'(flush_o[e]), 32'(ex_branch_taken));
            check($sformatf("illegal[%0d]", e), 32'(illegal_o[e]), 32'(id_valid && !n.legal));
            check($sformatf("fwd_a[%0d]", e), 32'(fwd_a_o[e]), 32'(exp_fwd(e, ex_m[e].rs)));
            check($sformatf("fwd_b[%0d]", e), 32'(fwd_b_o[e]), 32'(exp_fwd(e, ex_m[e].rt)));
            check($sformatf("ex_bundle[%0d]", e), dut_ex(e), model_ex(e));
            check($sformatf("mem_bundle[%0d]", e), dut_mem(e), model_mem(e));
            check($sformatf("wb_bundle[%0d]", e), dut_wb(e), model_wb(e));
        end
    endtask

    // Advance one clock; the model retires/accepts instructions on the same edge.
    task automatic tick();
        @(posedge clk);
        for (int e = 0; e < 2; e++) begin
            ins_t n;
            logic st;
            n  = decode(id_op, id_rs, id_rt, id_rd, e == 1);
            st = exp_stall(e);
            if (rst) begin
                ex_m[e] = '0; mem_m[e] = '0; wb_m[e] = '0;
            end else begin
                wb_m[e]  = mem_m[e];
                mem_m[e] = ex_m[e];
                ex_m[e]  = (id_valid && !ex_branch_taken && !st) ? n : '0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic br);
        drive(r, v, op, rs, rt, rd, br);
        model_check();
        tick();
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] tbl [4];
        tbl[0] = 5'd0; tbl[1] = 5'd5; tbl[2] = 5'd8; tbl[3] = 5'd31;
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return tbl[$urandom_range(0, 3)];
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [14];
        tbl[0]  = 6'b000000; tbl[1]  = 6'b100011; tbl[2]  = 6'b101011;
        tbl[3]  = 6'b000100; tbl[4]  = 6'b000101; tbl[5]  = 6'b001100;
        tbl[6]  = 6'b001000; tbl[7]  = 6'b001101; tbl[8]  = 6'b000011;
        tbl[9]  = 6'b001010; tbl[10] = 6'b001110; tbl[11] = 6'b001111;
        tbl[12] = 6'b000010; tbl[13] = 6'b100011;
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 13)];
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        for (int e = 0; e < 2; e++) begin
            ex_m[e] = '0; mem_m[e] = '0; wb_m[e] = '0;
        end

        // Reset held two cycles with a load presented in ID.
        drive(1, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
        tick();
        step(1, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);

        // First cycle after reset: pipeline still empty, lw r8 enters EX.
        drive(0, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
        model_check();
        check("rst_ex_valid", 32'(ex_valid_o[1]), 32'd0);
        check("rst_stall", 32'(stall_o[1]), 32'd0);
        tick();

        // Load-use: add rs=8 behind lw r8.
        drive(0, 1, OP_RT, 5'd8, 5'd2, 5'd3, 0);
        model_check();
        check("lu_ex_valid", 32'(ex_valid_o[1]), 32'd1);
        check("lu_stall", 32'(stall_o[1]), 32'd1);
        tick();
        drive(0, 1, OP_RT, 5'd8, 5'd2, 5'd3, 0);
        model_check();
        check("lu_bubble", 32'(ex_valid_o[1]), 32'd0);
        check("lu_stall_once", 32'(stall_o[1]), 32'd0);
        tick();
        drive(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        model_check();
        check("lu_fwd_a", 32'(fwd_a_o[1]), 32'd1);
        tick();

        // No stall against a load to r0.
        step(0, 1, OP_LW, 5'd1, 5'd0, 5'd0, 0);
        drive(0, 1, OP_RT, 5'd0, 5'd0, 5'd4, 0);
        model_check();
        check("lw_r0_stall", 32'(stall_o[1]), 32'd0);
        tick();

        // No stall when rt of an I-type matches the load destination.
        step(0, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
        drive(0, 1, OP_ADDI, 5'd1, 5'd8, 5'd0, 0);
        model_check();
        check("addi_rt_stall", 32'(stall_o[1]), 32'd0);
        tick();

        // Two producers of r5 in flight: the newer one wins.
        step(0, 1, OP_RT, 5'd1, 5'd2, 5'd5, 0);
        step(0, 1, OP_RT, 5'd1, 5'd2, 5'd5, 0);
        step(0, 1, OP_RT, 5'd5, 5'd5, 5'd9, 0);
        drive(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        model_check();
        check("prio_fwd_a", 32'(fwd_a_o[1]), 32'd2);
        check("prio_fwd_b", 32'(fwd_b_o[1]), 32'd2);
        tick();

        // Taken branch coinciding with a load-use hazard.
        step(0, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
        drive(0, 1, OP_RT, 5'd8, 5'd8, 5'd3, 1);
        model_check();
        check("fl_flush", 32'(flush_o[1]), 32'd1);
        check("fl_stall", 32'(stall_o[1]), 32'd0);
        tick();
        drive(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        model_check();
        check("fl_bubble", 32'(ex_valid_o[1]), 32'd0);
        check("fl_load_mem", 32'(mem_memread_o[1]), 32'd1);
        tick();

        // jal reaches WB three cycles later writing the link register.
        step(0, 1, OP_JAL, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        drive(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        model_check();
        check("jal_wb_dest", 32'(wb_dest_o[1]), 32'd31);
        check("jal_wb_jal", 32'(wb_jal_o[1]), 32'd1);
        check("jal_wb_regwrite", 32'(wb_regwrite_o[1]), 32'd1);
        tick();

        // lui: illegal without the extension, aluop 111 with it.
        drive(0, 1, OP_LUI, 5'd3, 5'd4, 5'd0, 0);
        model_check();
        check("lui_illegal_base", 32'(illegal_o[0]), 32'd1);
        check("lui_illegal_ext", 32'(illegal_o[1]), 32'd0);
        tick();
        drive(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        model_check();
        check("lui_aluop_base", 32'(ex_aluop_o[0]), 32'd1);
        check("lui_aluop_ext", 32'(ex_aluop_o[1]), 32'd7);
        check("lui_dest_base", 32'(ex_dest_o[0]), 32'd0);
        check("lui_dest_ext", 32'(ex_dest_o[1]), 32'd4);
        tick();
        drive(0, 0, OP_RT, 5'd0, 5'd0, 5'd0, 0);
        model_check();
        check("lui_regwrite_base", 32'(mem_regwrite_o[0]), 32'd0);
        check("lui_memwrite_base", 32'(mem_memwrite_o[0]), 32'd0);
        check("lui_regwrite_ext", 32'(mem_regwrite_o[1]), 32'd1);
        tick();

        // Randomized traffic, including occasional mid-stream resets.
        repeat (3000) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) != 0,
                 pick_op(), pick_reg(), pick_reg(), pick_reg(),
                 $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_hazard.md
# ctrl_pipe_hazard

Parametrised successor to the pipeline control decoder. It decodes the ID-stage opcode and carries the resulting control bundle through registered ID/EX, EX/MEM and MEM/WB stages. It also detects load-use hazards (stall plus bubble), squashes wrong-path instructions when a branch resolves taken in EX, and produces EX operand forwarding selects. It sits between the IF/ID register and the datapath pipeline registers. The datapath keeps only data registers; all control state lives here.

## Interface
Parameters:
- REG_ADDR_W, 5: register-specifier width. Register `(1<<REG_ADDR_W)-1` is the link register.
- ALUOP_W, 3: ALU operation code width. Must be ≥3.
- EXT_ISA, 1: 1 enables slti (001010), xori (001110), lui (001111) and j (000010). 0 makes these opcodes illegal.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_op  in  6  opcode.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register specifiers.
- ex_branch_taken  in  1  the branch in EX resolved taken (beq or bne).
- stall  out  1  combinational; hold PC and IF/ID.
- flush  out  1  combinational; clear IF/ID.
- id_illegal  out  1  combinational; id_valid and the opcode is not supported.
- ex_valid, ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_zext, ex_rtype, ex_memread  out  1 each.
- ex_aluop  out  ALUOP_W.
- ex_rs, ex_rt, ex_dest  out  REG_ADDR_W.
- fwd_a, fwd_b  out  2  combinational; 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_jal  out  1 each.
- mem_dest  out  REG_ADDR_W.
- wb_valid, wb_regwrite, wb_memtoreg, wb_jal  out  1 each.
- wb_dest  out  REG_ADDR_W.

## Operation
- Decode table, all fields 0 unless listed:
  - R-type 000000: regdst, aluop=010, regwrite, rtype.
  - lw 100011: alusrc, memtoreg, regwrite, memread.
  - sw 101011: alusrc, memwrite.
  - beq 000100: branch, aluop=001.
  - bne 000101: bne, aluop=001.
  - andi 001100: alusrc, aluop=100, regwrite, zext.
  - addi 001000: alusrc, regwrite.
  - ori 001101: alusrc, aluop=011, regwrite, zext.
  - jal 000011: jal, regwrite.
  - EXT_ISA only: slti aluop=101, alusrc, regwrite. xori aluop=110, alusrc, regwrite, zext. lui aluop=111, alusrc, regwrite. j no writes.
- Illegal opcodes: aluop=001, no writes, id_illegal=1. The instruction still enters the pipeline as a valid no-effect instruction.
- Destination register:
  - jal: all-ones (link register).
  - regdst: rd.
  - otherwise: rt.
  - No regwrite: dest=0.
- rt is a source only for R-type, sw, beq and bne.
- Load-use hazard: stall=1 when all of the following hold:
  - id_valid, ex_valid and ex_memread;
  - ex_dest≠0;
  - ex_dest equals id_rs, or ex_dest equals id_rt and rt is a source.
- flush = ex_branch_taken. flush has priority over stall: while flush=1, stall is forced to 0.
- ID/EX load rule: on a stall or flush, or when id_valid=0, ID/EX loads a bubble (all controls 0, valid 0, specifiers 0). Otherwise ID/EX loads the decoded bundle.
- EX/MEM and MEM/WB always advance. A stall never freezes them.
- Forwarding for operand A, using ex_rs:
  - 10 when mem_valid, mem_regwrite, mem_dest≠0 and mem_dest==ex_rs.
  - Else 01 under the same conditions on the wb_* signals.
  - Else 00.
- Forwarding for operand B uses ex_rt with the same rules.

## Timing
- Reset: every registered output is 0 on the edge where rst=1. rst overrides stall and flush.
- Combinational outputs after reset: stall=0, flush=ex_branch_taken, fwd_a=fwd_b=00.
- Latency: a decoded instruction appears on ex_* 1 cycle after the ID cycle, on mem_* after 2 cycles, and on wb_* after 3.
- stall, flush, id_illegal and the forwarding selects derive only from current inputs and registered state. There are no internal combinational loops.
- A load-use stall lasts exactly one cycle. The following cycle has a bubble in EX, so no hazard remains against the load.
- Taken branch: the EX instruction proceeds to MEM, and the ID instruction becomes a bubble. IF clearing is the consumer's job, using flush.
- rst asserted mid-stream: all in-flight instructions are discarded within that edge.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 and op=lw → all ex_/mem_/wb_ outputs 0 and stall=0. The first decode appears on ex_* one cycle after rst falls.
- Load-use: lw writing r8, then add with rs=8 → stall=1 for one cycle and ex_valid=0 in the next cycle. A cycle later the add reaches EX with fwd_a=01.
- Load-use false positives:
  - lw r0 followed by a use of r0 → no stall.
  - lw r8 followed by addi with rt=8 → no stall.
- Forwarding priority: add r5 followed by add r5 followed by add with rs=5 and rt=5 → fwd_a=fwd_b=10 (the newer producer wins).
- Flush beats stall: ex_branch_taken=1 in the same cycle a load-use hazard exists → flush=1, stall=0, ID/EX bubble.
- jal and illegal opcode: jal → wb_dest=31, wb_jal=1, wb_regwrite=1. With EXT_ISA=0, op=001111 → id_illegal=1, ex_aluop=001, no regwrite or memwrite. With EXT_ISA=1, the same opcode → ex_aluop=111, regwrite=1.
